muxed7_scan_ctrl_n: RTL and testbench

//  Parametrised multi-digit multiplexed 7-segment display controller for the calculator output unit.

---
 rtl/muxed7_scan_ctrl_n.sv | 126 ++++++++++++
 tb/tb_muxed7_scan_ctrl_n.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/muxed7_scan_ctrl_n.sv
// Multiplexed N-digit hex 7-segment scanner. New data is double-buffered and
// committed only at frame boundaries. Adds decimal points, leading-zero blanking and PWM dimming.
module muxed7_scan_ctrl_n #(
  parameter int N_DIG    = 4,
  parameter int PRESCALE = 50000,
  parameter int BRIGHT_W = 3,
  parameter int ACT_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [4*N_DIG-1:0]   hex_in,
  input  logic [N_DIG-1:0]     dp_in,
  input  logic                 blank_lz,
  input  logic [BRIGHT_W-1:0]  bright,
  output logic [N_DIG-1:0]     DIG,
  output logic [0:6]           SGNL,
  output logic                 DP,
  output logic                 upd_done
);

  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam bit OFF = (ACT_LOW != 0);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t               state;
  logic [PW-1:0]        pre_cnt;
  logic [IW-1:0]        idx;
  logic [4*N_DIG-1:0]   act_hex, sh_hex;
  logic [N_DIG-1:0]     act_dp, sh_dp;

  logic                 tick, last_slot, commit;
  logic [31:0]          on_t;
  logic [N_DIG-1:0]     zero_up, dig_on;
  logic                 acc, blank, lit;
  logic [3:0]           nib;
  logic [0:6]           seg;

  assign tick      = (pre_cnt == PW'(PRESCALE - 1));
  assign last_slot = (idx == IW'(N_DIG - 1));
  assign commit    = (state == PENDING) && tick && last_slot;

  always_comb begin
    on_t = ((32'(bright) + 32'd1) * 32'(PRESCALE - 1)) >> BRIGHT_W;
    if (on_t == 32'd0) on_t = 32'd1;

    // zero_up[i]: nibbles and dps from digit i up to the top are all clear
    zero_up = '0;
    acc     = 1'b1;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      acc        = acc && (act_hex[4*i +: 4] == 4'h0) && !act_dp[i];
      zero_up[i] = acc;
    end
    blank = blank_lz && (idx != '0) && zero_up[idx];

    // pre_cnt==0 stays dark as a gap between digits
    lit = (pre_cnt != '0) && (32'(pre_cnt) <= on_t) && !blank;

    nib = act_hex[{idx, 2'b00} +: 4];
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase

    dig_on      = '0;
    dig_on[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      idx      <= '0;
      act_hex  <= '0;
      act_dp   <= '0;
      sh_hex   <= '0;
      sh_dp    <= '0;
      upd_done <= 1'b0;
      DIG      <= {N_DIG{OFF}};
      SGNL     <= {7{OFF}};
      DP       <= OFF;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        idx     <= last_slot ? '0 : idx + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end

      // commit takes the old shadow; a same-cycle load refills it and keeps PENDING
      upd_done <= commit;
      if (commit) begin
        act_hex <= sh_hex;
        act_dp  <= sh_dp;
      end
      if (load) begin
        sh_hex <= hex_in;
        sh_dp  <= dp_in;
        state  <= PENDING;
      end else if (commit) begin
        state  <= IDLE;
      end

      DIG  <= (lit ? dig_on : '0) ^ {N_DIG{OFF}};
      SGNL <= (lit ? seg : 7'b0) ^ {7{OFF}};
      DP   <= (lit & act_dp[idx]) ^ OFF;
    end
  end

endmodule

// File: tb/tb_muxed7_scan_ctrl_n.sv
// Bench for muxed7_scan_ctrl_n: directed scenarios then random traffic, all outputs
// checked every cycle against a frame-arithmetic reference model.
module tb_muxed7_scan_ctrl_n;
  localparam int N = 4, P = 8, BW = 3;

  logic        clk = 1'b0;
  logic        rst, load, blank_lz;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [2:0]  bright;
  logic [3:0]  DIG;
  logic [0:6]  SGNL;
  logic        DP, upd_done;

  muxed7_scan_ctrl_n #(.N_DIG(N), .PRESCALE(P), .BRIGHT_W(BW), .ACT_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .hex_in(hex_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .bright(bright), .DIG(DIG), .SGNL(SGNL), .DP(DP),
    .upd_done(upd_done));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int c;                       // cycles since reset release
  logic [15:0] act_hex, sh_hex;
  logic [3:0]  act_dp, sh_dp;
  bit          pend;
  int          pulse_t[$];

  // a..g with a as MSB
  logic [6:0] segtab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h at c=%0d", tag, obs, exp, c);
    end
  endtask

  task automatic model_reset();
    c = 0; act_hex = '0; sh_hex = '0; act_dp = '0; sh_dp = '0; pend = 0;
  endtask

  task automatic cyc();
    int pre, id, ont;
    logic [3:0] nib, edig;
    logic [6:0] eseg;
    logic edp;
    bit blank, lit, com;
    pre = c % P;
    id  = (c / P) % N;
    ont = ((int'(bright) + 1) * (P - 1)) >> BW;
    if (ont < 1) ont = 1;
    nib   = act_hex[4*id +: 4];
    blank = blank_lz && id > 0 && (act_hex >> (4*id)) == 0 && (act_dp >> id) == 0;
    lit   = pre >= 1 && pre <= ont && !blank;
    edig  = lit ? ~(4'b0001 << id) : 4'hF;
    eseg  = lit ? ~segtab[nib] : 7'h7F;
    edp   = lit ? ~act_dp[id] : 1'b1;
    com   = pend && pre == P - 1 && id == N - 1;
    if (com) begin act_hex = sh_hex; act_dp = sh_dp; pend = 0; end
    if (load) begin sh_hex = hex_in; sh_dp = dp_in; pend = 1; end
    @(posedge clk); #1;
    c++;
    chk("dig", 32'(DIG), 32'(edig));
    chk("seg", 32'(SGNL), 32'(eseg));
    chk("dp", 32'(DP), 32'(edp));
    chk("upd", 32'(upd_done), 32'(com));
    if (upd_done) pulse_t.push_back(c);
  endtask

  task automatic run_to(input int target);
    while (c < target) cyc();
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] d);
    hex_in = h; dp_in = d; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_dig", 32'(DIG), 32'hF);
    chk("rst_seg", 32'(SGNL), 32'h7F);
    chk("rst_dp", 32'(DP), 32'h1);
    chk("rst_upd", 32'(upd_done), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 0; hex_in = '0; dp_in = '0; blank_lz = 0; bright = 3'd7;
    #1;
    do_reset();

    // load at cycle 3 commits at the end of frame 0
    pulse_t.delete();
    run_to(3);
    do_load(16'h1234, 4'h0);
    run_to(72);
    chk("t2_npulse", pulse_t.size(), 1);
    if (pulse_t.size() > 0) chk("t2_pulse_t", pulse_t[0], 32);

    // reset mid-scan with data displayed
    run_to(77);
    do_reset();

    // two loads in one frame: single commit of the last one
    pulse_t.delete();
    run_to(2);
    do_load(16'h1111, 4'h0);
    run_to(10);
    do_load(16'h2222, 4'h0);
    run_to(80);
    chk("t3_npulse", pulse_t.size(), 1);

    // leading-zero blanking, then a dp keeps digit 2 lit
    blank_lz = 1'b1;
    do_load(16'h0050, 4'h0);
    run_to(160);
    do_load(16'h0050, 4'b0100);
    run_to(224);

    // brightness extremes and middle
    bright = 3'd0; run_to(256);
    bright = 3'd3; run_to(288);
    bright = 3'd7;

    // load exactly on the commit cycle
    pulse_t.delete();
    run_to(293);
    do_load(16'hABCD, 4'h1);
    run_to(319);
    do_load(16'hEF09, 4'h8);
    run_to(400);
    chk("t6_npulse", pulse_t.size(), 2);
    if (pulse_t.size() == 2) chk("t6_gap", pulse_t[1] - pulse_t[0], 32);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) bright = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom_range(0, 1));
      load   = ($urandom_range(0, 19) == 0);
      hex_in = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      dp_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cyc();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
